md_seq_unit: RTL and testbench

//  Multi-cycle multiply/divide sequencer with HI/LO register file for the MiniSys1A EX stage.

---
 rtl/md_seq_unit.sv | 192 +++++++++++++++++++
 tb/tb_md_seq_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/md_seq_unit.sv
// Multi-cycle multiply/divide sequencer with HI/LO register file for the EX stage.
// Optional MD_EARLY_OUT_EN: divides with |dividend| < |divisor| finish in two cycles.
module md_seq_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [1:0]       alu_md,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic             op_mfhi,
    input  logic             op_mflo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned CNT_MAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned PROD_W  = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               commit_c;
    logic               start_c;

    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_signed;
    logic [WIDTH-1:0]   quo, rem, dmag;
    logic               neg_q, neg_r;

    logic               a_sgn, b_sgn, div_zero, early_c;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     shifted, diff;
    logic [PROD_W-1:0]  ext_a, ext_b, prod_c;

    // Operand signs and magnitudes for the divide path (sampled at issue)
    assign a_sgn    = ~alu_md[0] & op_a[WIDTH-1];
    assign b_sgn    = ~alu_md[0] & op_b[WIDTH-1];
    assign a_mag    = a_sgn ? WIDTH'(~op_a + WIDTH'(1)) : op_a;
    assign b_mag    = b_sgn ? WIDTH'(~op_b + WIDTH'(1)) : op_b;
    assign div_zero = (op_b == '0);
`ifdef MD_EARLY_OUT_EN
    assign early_c  = ~div_zero & (a_mag < b_mag);
`else
    assign early_c  = 1'b0;
`endif

    assign start_c  = (state_q == IDLE) & md_start & ~flush;

    assign ext_a  = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
    assign ext_b  = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
    assign prod_c = ext_a * ext_b;

    // One restoring-division step: shift in next dividend bit, trial subtract
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dmag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d != IDLE);
            done    <= commit_c;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_start) begin
                        cnt_d = '0;
                        if (!alu_md[1])             state_d = MUL;
                        else if (div_zero || early_c) state_d = FIX;
                        else                         state_d = DIV;
                    end
                end
                MUL: begin
                    if (cnt_q == CNT_W'(MULT_CYCLES - 1)) begin
                        commit_c = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (cnt_q == CNT_W'(1)) begin
                        commit_c = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: operand capture, divide iteration, sign fixup, HI/LO file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            quo        <= '0;
            rem        <= '0;
            dmag       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            if (start_c) begin
                mul_a      <= op_a;
                mul_b      <= op_b;
                mul_signed <= ~alu_md[0];
                dmag       <= b_mag;
                if (div_zero || early_c) begin
                    quo   <= div_zero ? '1 : '0;
                    rem   <= op_a;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    quo   <= a_mag;
                    rem   <= '0;
                    neg_q <= a_sgn ^ b_sgn;
                    neg_r <= a_sgn;
                end
            end else if (state_q == DIV) begin
                if (!diff[WIDTH]) begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end else if (state_q == FIX && cnt_q == '0) begin
                quo <= neg_q ? WIDTH'(~quo + WIDTH'(1)) : quo;
                rem <= neg_r ? WIDTH'(~rem + WIDTH'(1)) : rem;
            end

            if (commit_c) begin
                if (state_q == MUL) begin
                    {hi, lo} <= prod_c;
                end else begin
                    hi <= rem;
                    lo <= quo;
                end
            end else if (state_q == IDLE && !md_start && !flush) begin
                if (op_mthi) hi <= wdata;
                if (op_mtlo) lo <= wdata;
            end
        end
    end

    assign stall = busy & (md_start | op_mthi | op_mtlo | op_mfhi | op_mflo);
    assign rdata = op_mfhi ? hi : (op_mflo ? lo : '0);

endmodule

// File: tb/tb_md_seq_unit.sv
// Self-checking bench for md_seq_unit (WIDTH=32, MULT_CYCLES=4) using a result scoreboard.
module tb_md_seq_unit;

    logic        clk, rst;
    logic        md_start;
    logic [1:0]  alu_md;
    logic [31:0] op_a, op_b, wdata;
    logic        op_mthi, op_mtlo, op_mfhi, op_mflo, flush;
    logic        busy, stall, done;
    logic [31:0] hi, lo, rdata;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    md_seq_unit #(.WIDTH(32), .MULT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .md_start(md_start), .alu_md(alu_md),
        .op_a(op_a), .op_b(op_b), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
        .op_mfhi(op_mfhi), .op_mflo(op_mflo), .wdata(wdata), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic [32:0]        am, bm;
        if (!op[1]) begin
            if (!op[0]) begin
                ps = 64'($signed(a)) * 64'($signed(b));
                {e.hi, e.lo} = ps;
            end else begin
                pu = 64'(a) * 64'(b);
                {e.hi, e.lo} = pu;
            end
            e.lat = 4;
        end else begin
            e.lat = 34;
            if (b == 32'h0) begin
                e.lo = 32'hFFFF_FFFF; e.hi = a; e.lat = 2;
            end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000; e.hi = 32'h0;
            end else if (!op[0]) begin
                e.lo = $signed(a) / $signed(b);
                e.hi = $signed(a) % $signed(b);
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
`ifdef MD_EARLY_OUT_EN
            am = (!op[0] && a[31]) ? 33'(-$signed(a)) : {1'b0, a};
            bm = (!op[0] && b[31]) ? 33'(-$signed(b)) : {1'b0, b};
            if (b != 32'h0 && am < bm) e.lat = 2;
`else
            am = 33'(a);
            bm = 33'(b);
            if (am[32] ^ bm[32]) e.lat = e.lat;
`endif
        end
        return e;
    endfunction

    // Issue one mult/div, then compare latency and result against the scoreboard head
    task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_mflo);
        exp_t e;
        int   k, busy_n, bad_stall;
        bit   seen;
        sb.push_back(model(op, a, b));
        md_start = 1'b1; alu_md = op; op_a = a; op_b = b;
        @(posedge clk); @(negedge clk);
        md_start = 1'b0;
        check_eq("busy_after_issue", 64'(busy), 64'd1);
        busy_n = 0; bad_stall = 0; seen = 1'b0; k = 0;
        while (k < 100 && !seen) begin
            k++;
            if (hold_mflo && k == 2) op_mflo = 1'b1;
            @(posedge clk); @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_n++;
                if (hold_mflo && k >= 2 && !stall) bad_stall++;
            end
        end
        e = sb.pop_front();
        check_eq("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_eq("latency", 64'(k), 64'(e.lat));
            check_eq("hi", 64'(hi), 64'(e.hi));
            check_eq("lo", 64'(lo), 64'(e.lo));
            check_eq("busy_cycles", 64'(busy_n), 64'(e.lat - 1));
            check_eq("busy_at_done", 64'(busy), 64'd0);
            if (hold_mflo) begin
                check_eq("stall_while_busy", 64'(bad_stall), 64'd0);
                check_eq("stall_at_done", 64'(stall), 64'd0);
                check_eq("rdata_mflo", 64'(rdata), 64'(e.lo));
            end
            @(posedge clk); @(negedge clk);
            check_eq("done_one_pulse", 64'(done), 64'd0);
        end
        op_mflo = 1'b0;
    endtask

    task automatic move(input bit to_hi, input bit to_lo, input logic [31:0] v);
        op_mthi = to_hi; op_mtlo = to_lo; wdata = v;
        @(posedge clk); @(negedge clk);
        op_mthi = 1'b0; op_mtlo = 1'b0;
    endtask

    initial begin
        int done_n;
        logic [31:0] ra, rb;
        rst = 1'b1; md_start = 1'b0; alu_md = 2'b00; op_a = '0; op_b = '0; wdata = '0;
        op_mthi = 1'b0; op_mtlo = 1'b0; op_mfhi = 1'b0; op_mflo = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);

        move(1'b1, 1'b0, 32'hCAFE_0001);
        move(1'b0, 1'b1, 32'h0BAD_0002);
        op_mfhi = 1'b1; #1;
        check_eq("mfhi", 64'(rdata), 64'hCAFE_0001);
        op_mfhi = 1'b0; op_mflo = 1'b1; #1;
        check_eq("mflo", 64'(rdata), 64'h0BAD_0002);
        op_mflo = 1'b0; #1;
        check_eq("rdata_idle", 64'(rdata), 64'd0);
        check_eq("stall_idle", 64'(stall), 64'd0);

        do_md(2'b00, 32'hFFFF_FFFD, 32'h5, 1'b0);
        do_md(2'b01, 32'hFFFF_FFFF, 32'h2, 1'b0);
        do_md(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0);
        do_md(2'b11, 32'd100, 32'h0, 1'b0);
        do_md(2'b11, 32'd10, 32'd3, 1'b1);
        do_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_md(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
        do_md(2'b10, 32'h0000_0003, 32'h0000_0009, 1'b0);
        do_md(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_md(2'b10, 32'hFFFF_FF00, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            do_md(2'($urandom_range(0, 3)), ra, rb, 1'b0);
        end

        // Abort a divide mid-flight: HI/LO must keep the pre-op values
        move(1'b1, 1'b1, 32'h1234);
        md_start = 1'b1; alu_md = 2'b10; op_a = 32'h100; op_b = 32'd3;
        @(posedge clk); @(negedge clk);
        md_start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        done_n = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (done) done_n++;
        end
        check_eq("flush_no_done", 64'(done_n), 64'd0);
        check_eq("flush_hilo", {hi, lo}, {32'h1234, 32'h1234});

        // md_start coincident with flush is discarded
        md_start = 1'b1; flush = 1'b1; alu_md = 2'b00;
        @(posedge clk); @(negedge clk);
        md_start = 1'b0; flush = 1'b0;
        check_eq("flush_start_busy", 64'(busy), 64'd0);
        check_eq("flush_start_hilo", {hi, lo}, {32'h1234, 32'h1234});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
